// File: rtl/axis_sample_framer_if.sv
// Signal bundle for axis_sample_framer: strobe-only sample input, AXI4-Stream
// output and FIFO status. The master modport is the framer's own view.
interface axis_sample_framer_if #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10
);
    logic signed [SAMPLE_WIDTH-1:0] SAMPLE_DATA;
    logic                           SAMPLE_VALID;
    logic [DATA_WIDTH-1:0]          M_AXIS_TDATA;
    logic                           M_AXIS_TVALID;
    logic                           M_AXIS_TLAST;
    logic                           M_AXIS_TREADY;
    logic [ADDR_WIDTH:0]            FIFO_LEVEL;
    logic                           OVERFLOW;
    logic [15:0]                    DROP_COUNT;

    modport master (
        input  SAMPLE_DATA,
        input  SAMPLE_VALID,
        input  M_AXIS_TREADY,
        output M_AXIS_TDATA,
        output M_AXIS_TVALID,
        output M_AXIS_TLAST,
        output FIFO_LEVEL,
        output OVERFLOW,
        output DROP_COUNT
    );

    modport slave (
        output SAMPLE_DATA,
        output SAMPLE_VALID,
        output M_AXIS_TREADY,
        input  M_AXIS_TDATA,
        input  M_AXIS_TVALID,
        input  M_AXIS_TLAST,
        input  FIFO_LEVEL,
        input  OVERFLOW,
        input  DROP_COUNT
    );
endinterface

// File: rtl/axis_sample_framer.sv
// Buffers strobed audio samples in a first-word-fall-through FIFO and emits them
// as a framed AXI4-Stream; overflowing samples are dropped and counted.
module axis_sample_framer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_LEN    = 512,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESET,
    axis_sample_framer_if.master bus
);

    if (DATA_WIDTH < SAMPLE_WIDTH) begin : g_bad_width
        $error("axis_sample_framer: DATA_WIDTH must be >= SAMPLE_WIDTH");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 65535) begin : g_bad_frame
        $error("axis_sample_framer: FRAME_LEN must be in 2..65535");
    end

    localparam int unsigned         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [15:0]         LAST_BEAT  = 16'(FRAME_LEN - 1);

    logic signed [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]          r_wr_ptr;
    logic [ADDR_WIDTH-1:0]          r_rd_ptr;
    logic [ADDR_WIDTH:0]            r_level;
    logic [15:0]                    r_beat_cnt;
    logic [15:0]                    r_drop_cnt;
    logic                           r_overflow;

    logic                           w_full;
    logic                           w_valid;
    logic                           w_rd_hs;
    logic                           w_wr_en;
    logic                           w_drop;
    logic signed [SAMPLE_WIDTH-1:0] w_rd_sample;
    logic [ADDR_WIDTH:0]            w_level_next;

    // Full comes from the registered level, so a pointer match alone never means full.
    assign w_full      = (r_level == LEVEL_FULL);
    assign w_valid     = (r_level != '0);
    assign w_rd_hs     = w_valid & bus.M_AXIS_TREADY;
    assign w_wr_en     = bus.SAMPLE_VALID & (~w_full | w_rd_hs);
    assign w_drop      = bus.SAMPLE_VALID & w_full & ~w_rd_hs;
    assign w_rd_sample = r_mem[r_rd_ptr];

    always_comb begin
        w_level_next = r_level;
        case ({w_wr_en, w_rd_hs})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Storage is not reset; contents are only observable once the level says so.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESET && w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.SAMPLE_DATA;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_beat_cnt <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_level <= w_level_next;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_hs) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    // All outputs derive from registered state only; TREADY never reaches them.
    assign bus.M_AXIS_TDATA  = DATA_WIDTH'(w_rd_sample);
    assign bus.M_AXIS_TVALID = w_valid;
    assign bus.M_AXIS_TLAST  = w_valid & (r_beat_cnt == LAST_BEAT);
    assign bus.FIFO_LEVEL    = r_level;
    assign bus.OVERFLOW      = r_overflow;
    assign bus.DROP_COUNT    = r_drop_cnt;

endmodule

// File: doc/axis_sample_framer.md
Name: axis_sample_framer

Overview:
- Upstream neighbour of the AXI4-Stream broadcaster.
- Takes free-running audio samples from the audio capture front end, which is strobe-only and has no backpressure.
- Buffers the samples in an internal FIFO and emits them as a 32-bit AXI4-Stream, with TLAST marking the last sample of each FFT-sized frame.
- Absorbs downstream stalls. On overflow it drops samples and keeps drop statistics.

Parameters:
- SAMPLE_WIDTH, 24: signed input sample width.
- DATA_WIDTH, 32: output TDATA width; must be >= SAMPLE_WIDTH (elaboration error otherwise).
- FRAME_LEN, 512: beats per frame; TLAST on beat FRAME_LEN-1; legal range 2..65535.
- ADDR_WIDTH, 10: FIFO depth = 2^ADDR_WIDTH entries.

Ports:
- AXIS_ACLK  in  1  single clock; all logic on its rising edge.
- AXIS_ARESET  in  1  synchronous, active-high reset.
- SAMPLE_DATA  in  SAMPLE_WIDTH  signed audio sample.
- SAMPLE_VALID  in  1  one-cycle strobe; SAMPLE_DATA is valid this cycle.
- M_AXIS_TDATA  out  DATA_WIDTH  sign-extended sample.
- M_AXIS_TVALID  out  1  FIFO non-empty.
- M_AXIS_TLAST  out  1  current beat is the last of its frame.
- M_AXIS_TREADY  in  1  downstream ready; the broadcaster's AND of both consumers' TREADY.
- FIFO_LEVEL  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- OVERFLOW  out  1  sticky; set on any dropped sample.
- DROP_COUNT  out  16  dropped-sample count, saturating at 0xFFFF.

Behaviour:
- Reset (AXIS_ARESET=1 at a clock edge):
  - Pointers, FIFO_LEVEL, frame counter, OVERFLOW and DROP_COUNT all go to 0.
  - M_AXIS_TVALID=0 and M_AXIS_TLAST=0 from the next cycle.
  - M_AXIS_TDATA is don't-care while TVALID=0.
  - Reset mid-frame discards buffered data; the next emitted beat is beat 0 of a new frame.
  - A SAMPLE_VALID in a reset cycle is ignored.
- Write:
  - SAMPLE_VALID=1 and not full → store sample at wr_ptr; wr_ptr increments mod 2^ADDR_WIDTH.
  - Full is evaluated from the registered level at the start of the cycle.
  - If full but a read handshake occurs in the same cycle, the write is accepted and the level stays unchanged.
- Drop: SAMPLE_VALID=1, full, and no read handshake that cycle →
  - sample discarded;
  - OVERFLOW<=1 (cleared only by reset);
  - DROP_COUNT increments, holding at 0xFFFF.
- Read: first-word-fall-through.
  - M_AXIS_TVALID=1 whenever the registered level > 0.
  - M_AXIS_TDATA = sign-extension of the entry at rd_ptr.
  - Write-to-output latency is 1 cycle: a sample strobed into an empty FIFO at edge N is visible with TVALID=1 in the cycle after edge N.
  - Handshake (TVALID & TREADY) at an edge advances rd_ptr.
  - Once TVALID is asserted, TDATA, TLAST and TVALID stay stable until the handshake (AXI rule).
- Level: FIFO_LEVEL = level + write_accepted - read_handshake, registered. Simultaneous write and read leaves it unchanged.
- Frame counter:
  - beat_cnt, 16 bits, counts output handshakes only; wraps from FRAME_LEN-1 to 0.
  - M_AXIS_TLAST = TVALID & (beat_cnt == FRAME_LEN-1).
- Drops do not affect beat_cnt. Frames stay FRAME_LEN beats long, but a frame spanning a drop is not sample-contiguous; downstream relies on OVERFLOW to detect this.
- Empty with TREADY=1: no handshake, no counter change.
- Pointer wrap: both pointers wrap naturally at 2^ADDR_WIDTH. Full is level == 2^ADDR_WIDTH, not pointer equality alone.
- No combinational path from M_AXIS_TREADY to any output.

Test Plan:
- Reset, then strobe 3 samples 0x000001, 0xFFFFFE, 0x7FFFFF with TREADY=1 → TDATA 0x00000001, 0xFFFFFFFE, 0x007FFFFF, each 1 cycle after its strobe; FIFO_LEVEL returns to 0; TLAST never set.
- FRAME_LEN=4, strobe 0..9, TREADY=1 → TLAST on the beats carrying values 3 and 7; value 8 starts a new frame.
- TREADY=0, strobe 1030 samples with ADDR_WIDTH=10 → FIFO_LEVEL=1024, OVERFLOW=1, DROP_COUNT=6; then TREADY=1 → samples 0..1023 emerge in order and TVALID drops after 1024 beats.
- With FIFO full, hold TREADY=1 and strobe every cycle → no drops, FIFO_LEVEL stays 1024, DROP_COUNT unchanged.
- Random TREADY (50%) with a strobe every 4th cycle over 5000 samples → output equals input order, TLAST every 512 beats, TDATA/TVALID stable during stalls, OVERFLOW=0.
- Assert AXIS_ARESET mid-frame, at beat 200 with 37 entries buffered → next cycle TVALID=0, FIFO_LEVEL=0, OVERFLOW=0; the next frame's TLAST falls exactly 512 beats after reset release.
